// File: rtl/gat_debug_monitor.sv
// Debug monitor for the GAT pipeline: per-channel sticky/counter/first-timestamp, cycle timer, address watch.
// Readback is registered (1-cycle latency); no backpressure, inputs are sampled every cycle.
module gat_debug_monitor #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter logic [31:0] ADDR_THRESH = 32'd43328,
    parameter bit          COUNT_EDGE  = 1'b0,
    parameter int unsigned SEL_W       = $clog2(4 + 2 * NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] evt_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              addr_vld_i,
    input  logic              clr_i,
    input  logic              freeze_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [31:0]       rd_data_o,
    output logic [NUM_CH-1:0] sticky_o,
    output logic              addr_flag_o
);

    logic [NUM_CH-1:0] evt_q;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  ts_q  [NUM_CH];
    logic [CNT_W-1:0]  ts_d  [NUM_CH];
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_max_q, addr_max_d;
    logic [ADDR_W-1:0] addr_last_q, addr_last_d;
    logic              addr_flag_q, addr_flag_d;
    logic [31:0]       rd_q, rd_d;
    logic [31:0]       addr_ext;

    // evt_q tracks the raw input regardless of freeze/clear so a held level is never re-counted
    assign hit      = COUNT_EDGE ? (evt_i & ~evt_q) : evt_i;
    assign addr_ext = 32'(addr_i);

    always_comb begin
        timer_d     = timer_q;
        sticky_d    = sticky_q;
        addr_max_d  = addr_max_q;
        addr_last_d = addr_last_q;
        addr_flag_d = addr_flag_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            ts_d[k]  = ts_q[k];
        end
        if (clr_i) begin
            timer_d     = '0;
            sticky_d    = '0;
            addr_max_d  = '0;
            addr_last_d = '0;
            addr_flag_d = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_d[k] = '0;
                ts_d[k]  = '0;
            end
        end else if (!freeze_i) begin
            if (timer_q != '1) begin
                timer_d = timer_q + CNT_W'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (hit[k]) begin
                    if (cnt_q[k] != '1) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                    if (!sticky_q[k]) begin
                        ts_d[k] = timer_q;
                    end
                    sticky_d[k] = 1'b1;
                end
            end
            if (addr_vld_i) begin
                addr_last_d = addr_i;
                if (addr_i > addr_max_q) begin
                    addr_max_d = addr_i;
                end
                if (addr_ext >= ADDR_THRESH) begin
                    addr_flag_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        case (rd_sel_i)
            SEL_W'(0): begin
                rd_d[NUM_CH-1:0] = sticky_q;
                rd_d[31]         = addr_flag_q;
            end
            SEL_W'(1): rd_d = 32'(timer_q);
            SEL_W'(2): rd_d = 32'(addr_max_q);
            SEL_W'(3): rd_d = 32'(addr_last_q);
            default:   rd_d = '0;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(4 + k)) begin
                rd_d = 32'(cnt_q[k]);
            end
            if (rd_sel_i == SEL_W'(4 + NUM_CH + k)) begin
                rd_d = 32'(ts_q[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q       <= '0;
            timer_q     <= '0;
            sticky_q    <= '0;
            addr_max_q  <= '0;
            addr_last_q <= '0;
            addr_flag_q <= 1'b0;
            rd_q        <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
                ts_q[k]  <= '0;
            end
        end else begin
            evt_q       <= evt_i;
            timer_q     <= timer_d;
            sticky_q    <= sticky_d;
            addr_max_q  <= addr_max_d;
            addr_last_q <= addr_last_d;
            addr_flag_q <= addr_flag_d;
            rd_q        <= rd_d;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
                ts_q[k]  <= ts_d[k];
            end
        end
    end

    assign rd_data_o   = rd_q;
    assign sticky_o    = sticky_q;
    assign addr_flag_o = addr_flag_q;

endmodule

// File: tb/tb_gat_debug_monitor.sv
// Directed bench: d0 = level counting, 32-bit counters; d1 = edge counting, 4-bit counters. Shared stimulus.
module tb_gat_debug_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  evt;
    logic [15:0] addr;
    logic        addr_vld;
    logic        clr;
    logic        freeze;
    logic [4:0]  rd_sel;
    logic [31:0] rd0, rd1;
    logic [7:0]  sticky0, sticky1;
    logic        flag0, flag1;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned t     = 0;  // expected d0 cycle-timer value
    int unsigned tf    = 0;
    int unsigned ts0   = 0;
    logic [31:0] r0, r1;

    always #5 clk = ~clk;

    gat_debug_monitor #(.NUM_CH(8), .CNT_W(32), .ADDR_W(16), .ADDR_THRESH(32'd43328), .COUNT_EDGE(1'b0)) d0 (
        .clk(clk), .rst_n(rst_n), .evt_i(evt), .addr_i(addr), .addr_vld_i(addr_vld),
        .clr_i(clr), .freeze_i(freeze), .rd_sel_i(rd_sel), .rd_data_o(rd0),
        .sticky_o(sticky0), .addr_flag_o(flag0)
    );

    gat_debug_monitor #(.NUM_CH(8), .CNT_W(4), .ADDR_W(16), .ADDR_THRESH(32'd43328), .COUNT_EDGE(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .evt_i(evt), .addr_i(addr), .addr_vld_i(addr_vld),
        .clr_i(clr), .freeze_i(freeze), .rd_sel_i(rd_sel), .rd_data_o(rd1),
        .sticky_o(sticky1), .addr_flag_o(flag1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock edge, then settle 1 time unit past it before touching inputs or sampling
    task automatic tick();
        @(posedge clk);
        if (!rst_n || clr) t = 0;
        else if (!freeze) t++;
        #1;
    endtask

    task automatic rd(input int sel, output logic [31:0] o0, output logic [31:0] o1);
        rd_sel = 5'(sel);
        tick();
        o0 = rd0;
        o1 = rd1;
    endtask

    function automatic logic [31:0] sat4(input int unsigned v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    initial begin
        rst_n = 1'b0; evt = '0; addr = '0; addr_vld = 1'b0;
        clr = 1'b0; freeze = 1'b0; rd_sel = 5'd1;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_sticky0", 32'(sticky0), 32'h0);
        chk("rst_flag0", 32'(flag0), 32'h0);

        // 10 idle edges with sel 1: last read shows the timer before the 10th edge
        repeat (10) tick();
        chk("idle_timer0", rd0, 32'd9);
        chk("idle_timer1", rd1, 32'd9);
        for (int s = 0; s < 32; s++) begin
            if (s != 1) begin
                rd(s, r0, r1);
                chk($sformatf("idle_sel%0d_d0", s), r0, 32'h0);
                chk($sformatf("idle_sel%0d_d1", s), r1, 32'h0);
            end
        end

        // channel 2 held for 5 cycles starting at timer 7
        clr = 1'b1; tick(); clr = 1'b0;
        while (t < 7) tick();
        evt[2] = 1'b1;
        repeat (5) tick();
        evt[2] = 1'b0;
        chk("ch2_sticky0", 32'(sticky0), 32'h04);
        chk("ch2_sticky1", 32'(sticky1), 32'h04);
        rd(6, r0, r1);
        chk("ch2_cnt_lvl", r0, 32'd5);
        chk("ch2_cnt_edge", r1, 32'd1);
        rd(14, r0, r1);
        chk("ch2_ts0", r0, 32'd7);
        chk("ch2_ts1", r1, 32'd7);

        // 20 pulses on channel 0: 4-bit counter saturates at 15
        ts0 = t;
        repeat (20) begin
            evt[0] = 1'b1; tick();
            evt[0] = 1'b0; tick();
        end
        rd(4, r0, r1);
        chk("sat_cnt0", r0, 32'd20);
        chk("sat_cnt1", r1, 32'h0000000F);
        rd(12, r0, r1);
        chk("sat_ts0", r0, 32'(ts0));
        chk("sat_ts1", r1, sat4(ts0));
        tf = t;
        rd(1, r0, r1);
        chk("sat_timer0", r0, 32'(tf));
        chk("sat_timer1", r1, 32'd15);

        // address watch around the threshold
        addr_vld = 1'b1;
        addr = 16'd100;   tick(); chk("addr100_flag", 32'(flag0), 32'h0);
        addr = 16'd43327; tick(); chk("addr43327_flag", 32'(flag0), 32'h0);
        addr = 16'd43328; tick(); chk("addr43328_flag0", 32'(flag0), 32'h1);
        chk("addr43328_flag1", 32'(flag1), 32'h1);
        addr = 16'd200;   tick();
        addr_vld = 1'b0;
        rd(2, r0, r1);
        chk("addr_max0", r0, 32'd43328);
        chk("addr_max1", r1, 32'd43328);
        rd(3, r0, r1);
        chk("addr_last0", r0, 32'd200);
        rd(0, r0, r1);
        chk("sel0_d0", r0, 32'h80000005);
        chk("sel0_d1", r1, 32'h80000005);

        // freeze while channel 1 toggles
        freeze = 1'b1;
        tf = t;
        for (int i = 0; i < 6; i++) begin
            evt[1] = (i % 2 == 0);
            tick();
        end
        evt[1] = 1'b0;
        rd(5, r0, r1);
        chk("frz_cnt1_d0", r0, 32'h0);
        chk("frz_cnt1_d1", r1, 32'h0);
        rd(1, r0, r1);
        chk("frz_timer0", r0, 32'(tf));
        chk("frz_timer1", r1, 32'd15);
        rd(6, r0, r1);
        chk("frz_rd_live", r0, 32'd5);
        chk("frz_sticky0", 32'(sticky0), 32'h05);
        freeze = 1'b0;

        // clear wins over same-cycle event and address
        clr = 1'b1; evt[1] = 1'b1; addr_vld = 1'b1; addr = 16'd50000;
        tick();
        clr = 1'b0; addr_vld = 1'b0;
        chk("clr_sticky0", 32'(sticky0), 32'h0);
        chk("clr_sticky1", 32'(sticky1), 32'h0);
        chk("clr_flag0", 32'(flag0), 32'h0);
        rd(2, r0, r1);
        chk("clr_max0", r0, 32'h0);
        chk("clr_max1", r1, 32'h0);
        rd(5, r0, r1);
        chk("clr_cnt1_lvl", r0, 32'd1);
        chk("clr_cnt1_edge", r1, 32'd0);
        chk("clr_held_sticky0", 32'(sticky0), 32'h02);
        chk("clr_held_sticky1", 32'(sticky1), 32'h0);
        tf = t;
        rd(1, r0, r1);
        chk("clr_timer0", r0, 32'(tf));
        chk("clr_timer1", r1, 32'd2);

        // async reset mid-cycle with live state
        addr_vld = 1'b1; addr = 16'd60000;
        rd(5, r0, r1);
        addr_vld = 1'b0; evt = '0;
        chk("pre_rst_cnt", r0, 32'd3);
        chk("pre_rst_flag", 32'(flag0), 32'h1);
        #3;
        rst_n = 1'b0;
        t = 0;
        #1;
        chk("arst_rd0", rd0, 32'h0);
        chk("arst_rd1", rd1, 32'h0);
        chk("arst_sticky0", 32'(sticky0), 32'h0);
        chk("arst_flag0", 32'(flag0), 32'h0);
        chk("arst_flag1", 32'(flag1), 32'h0);
        #1;
        rst_n = 1'b1;
        rd(1, r0, r1);
        chk("post_rst_t0", r0, 32'd0);
        rd(1, r0, r1);
        chk("post_rst_t1", r0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
